// File: rtl/refresh_issuer.sv
// refresh_issuer
//   Refresh side of the write-aware refresh filter for one DRAM rank. It owns
//   the tREFI interval timer and the pending-refresh credit count. It queries
//   the filter for each refresh slot, and it either drops the slot as a dummy
//   refresh or requests an auto-refresh from the command scheduler. After a
//   grant it blocks the rank for tRFC.
//
// Ports
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   bus_idle    in   scheduler has no queued column traffic
//   dref        in   filter decision, valid the cycle after to_refresh (1=dummy)
//   ref_gnt     in   scheduler accepted the REF command (only used in REQ)
//   to_refresh  out  one-cycle query pulse to the filter
//   ref_req     out  auto-refresh request, held until ref_gnt
//   ref_busy    out  high for T_RFC cycles after the grant
//   ref_row     out  row pointer of the current slot
//   pending     out  outstanding refresh credits
//   urgent      out  pending == MAX_POSTPONE
//   overflow    out  sticky: a credit was lost at saturation
//   skip_cnt    out  number of dummy refreshes taken (saturating)
module refresh_issuer #(
  parameter int ROW_WIDTH    = 16,
  parameter int T_REFI       = 7800,
  parameter int T_RFC        = 350,
  parameter int MAX_POSTPONE = 8,
  parameter int PEND_W       = $clog2(MAX_POSTPONE + 1),
  parameter int SKIP_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bus_idle,
  input  logic                 dref,
  input  logic                 ref_gnt,
  output logic                 to_refresh,
  output logic                 ref_req,
  output logic                 ref_busy,
  output logic [ROW_WIDTH-1:0] ref_row,
  output logic [PEND_W-1:0]    pending,
  output logic                 urgent,
  output logic                 overflow,
  output logic [SKIP_W-1:0]    skip_cnt
);

  localparam int TMR_W = $clog2(T_REFI);
  localparam int RFC_W = $clog2(T_RFC + 1);

  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(T_REFI - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POSTPONE);
  localparam logic [RFC_W-1:0]  RFC_LOAD = RFC_W'(T_RFC);
  localparam logic [RFC_W-1:0]  RFC_LAST = RFC_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_QUERY  = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_REQ    = 3'd3;
  localparam logic [2:0] S_RFC    = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [RFC_W-1:0]     rfc_q, rfc_d;
  logic [PEND_W-1:0]    pending_q, pending_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [SKIP_W-1:0]    skip_q, skip_d;
  logic                 overflow_q, overflow_d;

  logic credit;
  logic dummy_done;
  logic gnt_done;
  logic slot_done;
  logic at_max;

  always_comb begin
    credit     = (timer_q == TMR_LAST);
    timer_d    = credit ? '0 : timer_q + 1'b1;

    dummy_done = (state_q == S_DECIDE) && dref;
    gnt_done   = (state_q == S_REQ) && ref_gnt;
    slot_done  = dummy_done || gnt_done;
    at_max     = (pending_q == PEND_MAX);

    // A credit and a completion in the same cycle cancel out. A lone credit
    // at saturation is dropped and remembered in the sticky overflow flag.
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (credit && !slot_done) begin
      if (at_max) overflow_d = 1'b1;
      else        pending_d  = pending_q + 1'b1;
    end else if (!credit && slot_done) begin
      pending_d = pending_q - 1'b1;
    end

    // The row pointer advances once per finished slot and wraps silently.
    row_d  = slot_done ? row_q + 1'b1 : row_q;
    skip_d = (dummy_done && (skip_q != '1)) ? skip_q + 1'b1 : skip_q;
  end

  always_comb begin
    state_d = state_q;
    rfc_d   = rfc_q;
    case (state_q)
      S_IDLE: begin
        if ((pending_q != '0) && (bus_idle || at_max)) state_d = S_QUERY;
      end
      S_QUERY: begin
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        state_d = dref ? S_IDLE : S_REQ;
      end
      S_REQ: begin
        if (ref_gnt) begin
          state_d = S_RFC;
          rfc_d   = RFC_LOAD;
        end
      end
      S_RFC: begin
        // The counter holds T_RFC..1 while in RFC, so RFC lasts T_RFC cycles.
        rfc_d = rfc_q - 1'b1;
        if (rfc_q == RFC_LAST) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      rfc_q      <= '0;
      pending_q  <= '0;
      row_q      <= '0;
      skip_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rfc_q      <= rfc_d;
      pending_q  <= pending_d;
      row_q      <= row_d;
      skip_q     <= skip_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake outputs are decodes of the state register, so they are glitch
  // free and clear immediately on asynchronous reset.
  assign to_refresh = (state_q == S_QUERY);
  assign ref_req    = (state_q == S_REQ);
  assign ref_busy   = (state_q == S_RFC);
  assign ref_row    = row_q;
  assign pending    = pending_q;
  assign urgent     = at_max;
  assign overflow   = overflow_q;
  assign skip_cnt   = skip_q;

endmodule

// File: tb/tb_refresh_issuer.sv
module tb_refresh_issuer;

  localparam int RW    = 4;
  localparam int TREFI = 16;
  localparam int TRFC  = 4;
  localparam int MAXP  = 8;
  localparam int PW    = 4;
  localparam int SW    = 8;

  logic          clk;
  logic          rst_n;
  logic          bus_idle;
  logic          dref;
  logic          ref_gnt;
  logic          to_refresh;
  logic          ref_req;
  logic          ref_busy;
  logic [RW-1:0] ref_row;
  logic [PW-1:0] pending;
  logic          urgent;
  logic          overflow;
  logic [SW-1:0] skip_cnt;

  refresh_issuer #(
    .ROW_WIDTH(RW), .T_REFI(TREFI), .T_RFC(TRFC),
    .MAX_POSTPONE(MAXP), .PEND_W(PW), .SKIP_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_idle(bus_idle), .dref(dref),
    .ref_gnt(ref_gnt), .to_refresh(to_refresh), .ref_req(ref_req),
    .ref_busy(ref_busy), .ref_row(ref_row), .pending(pending),
    .urgent(urgent), .overflow(overflow), .skip_cnt(skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int row;
    int skip;
    int pend;
    bit chk_pend;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  bit   gnt_en;
  int   gnt_delay;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int row, input int skip, input int pend, input bit cp);
    exp_t e;
    e.row = row; e.skip = skip; e.pend = pend; e.chk_pend = cp;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every advance of ref_row is a finished slot.
  task automatic monitor();
    logic [RW-1:0] last;
    exp_t e;
    last = ref_row;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = ref_row;
      end else if (ref_row !== last) begin
        last = ref_row;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_slot", int'(ref_row), -1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_row", int'(ref_row), e.row);
          chk("sb_skip", int'(skip_cnt), e.skip);
          if (e.chk_pend) chk("sb_pending", int'(pending), e.pend);
        end
      end
    end
  endtask

  // Scheduler model: grants gnt_delay cycles after ref_req first appears.
  task automatic granter();
    int gcnt;
    gcnt = 0;
    forever begin
      @(negedge clk);
      if (!gnt_en) begin
        gcnt = 0;
      end else if (ref_req) begin
        ref_gnt = (gcnt == gnt_delay);
        gcnt++;
      end else begin
        ref_gnt = 1'b0;
        gcnt = 0;
      end
    end
  endtask

  task automatic wait_pending(input int v, input int max, input string name);
    int n;
    n = 0;
    while (int'(pending) != v && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(pending), v);
  endtask

  task automatic wait_tor(input int max, input string name);
    int n;
    n = 0;
    while (!to_refresh && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(to_refresh), 1);
  endtask

  initial begin
    int t_query, n_req, n_busy, n;
    total = 0; bad = 0;
    rst_n = 1'b0; bus_idle = 1'b0; dref = 1'b0; ref_gnt = 1'b0;
    gnt_en = 1'b0; gnt_delay = 2;
    fork
      monitor();
      granter();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_to_refresh", int'(to_refresh), 0);
    chk("rst_ref_req", int'(ref_req), 0);
    chk("rst_ref_busy", int'(ref_busy), 0);
    chk("rst_ref_row", int'(ref_row), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_urgent", int'(urgent), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_skip_cnt", int'(skip_cnt), 0);

    // Auto path: query 17 edges after release, 3 req cycles, T_RFC busy cycles.
    bus_idle = 1'b1; gnt_en = 1'b1; gnt_delay = 2;
    push(1, 0, 0, 1'b1);
    rst_n = 1'b1;
    t_query = 0; n_req = 0; n_busy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == TREFI) chk("t1_first_credit", int'(pending), 1);
      if (to_refresh && t_query == 0) begin
        t_query = i;
        bus_idle = 1'b0;
      end
      if (ref_req) n_req++;
      if (ref_busy) n_busy++;
    end
    chk("t1_query_edge", t_query, TREFI + 1);
    chk("t1_req_cycles", n_req, 3);
    chk("t1_busy_cycles", n_busy, TRFC);

    // Dummy path: no request, slot finishes two cycles after the query.
    dref = 1'b1;
    wait_pending(1, 40, "t2_pending_one");
    push(2, 1, 0, 1'b1);
    bus_idle = 1'b1;
    wait_tor(4, "t2_query");
    bus_idle = 1'b0;
    n_req = 0;
    @(negedge clk);
    chk("t2_query_one_cycle", int'(to_refresh), 0);
    if (ref_req) n_req++;
    @(negedge clk);
    if (ref_req) n_req++;
    chk("t2_row_after_decide", int'(ref_row), 2);
    @(negedge clk);
    if (ref_req) n_req++;
    chk("t2_no_ref_req", n_req, 0);

    // Grant lands in the same cycle as a credit with pending=3.
    dref = 1'b0; gnt_en = 1'b0;
    wait_pending(3, 100, "t4_pending_three");
    push(3, 1, 3, 1'b1);
    bus_idle = 1'b1;
    @(negedge clk);
    chk("t4_query", int'(to_refresh), 1);
    bus_idle = 1'b0;
    repeat (14) @(negedge clk);
    chk("t4_req_held", int'(ref_req), 1);
    ref_gnt = 1'b1;
    @(negedge clk);
    ref_gnt = 1'b0;
    chk("t4_pending_kept", int'(pending), 3);
    chk("t4_busy", int'(ref_busy), 1);

    // Saturation: urgent forces a query, ungranted request, lost credit.
    wait_pending(8, 200, "t3_pending_max");
    chk("t3_urgent", int'(urgent), 1);
    wait_tor(4, "t3_urgent_query");
    n = 0;
    while (!ref_req && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("t3_ref_req", int'(ref_req), 1);
    chk("t3_no_overflow_yet", int'(overflow), 0);
    repeat (20) @(negedge clk);
    chk("t3_pending_sat", int'(pending), 8);
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_req_stable", int'(ref_req), 1);
    push(4, 1, 7, 1'b1);
    gnt_delay = 2; gnt_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_urgent_clear", int'(urgent), 0);
    chk("t3_overflow_sticky", int'(overflow), 1);

    // Row wrap through dummy slots: rows 5..15 then 0.
    dref = 1'b1;
    for (int r = 5; r <= 16; r++) push(r % 16, r - 3, 0, 1'b0);
    bus_idle = 1'b1;
    n = 0;
    while (int'(skip_cnt) != 13 && n < 400) begin
      @(negedge clk);
      n++;
    end
    bus_idle = 1'b0;
    chk("t5_skip_cnt", int'(skip_cnt), 13);
    chk("t5_row_wrapped", int'(ref_row), 0);
    chk("t5_overflow_kept", int'(overflow), 1);
    chk("t5_no_req", int'(ref_req), 0);

    // Reset in the middle of tRFC with pending=5.
    dref = 1'b0; gnt_delay = 0; gnt_en = 1'b1;
    wait_pending(6, 200, "t6_pending_six");
    push(1, 13, 5, 1'b1);
    bus_idle = 1'b1;
    @(negedge clk);
    bus_idle = 1'b0;
    n = 0;
    while (!ref_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_rfc", int'(ref_busy), 1);
    chk("t6_pending_five", int'(pending), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy_async", int'(ref_busy), 0);
    chk("t6_pending_async", int'(pending), 0);
    chk("t6_row_async", int'(ref_row), 0);
    chk("t6_skip_async", int'(skip_cnt), 0);
    chk("t6_overflow_async", int'(overflow), 0);
    chk("t6_req_async", int'(ref_req), 0);
    gnt_en = 1'b0;
    ref_gnt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (int'(pending) != 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_credit_edge", n, TREFI);
    chk("t6_no_busy", int'(ref_busy), 0);

    chk("sb_all_slots_seen", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
